reg_mem_sram_bridge: RTL

Terminal stage of the register-access memory path. Consumes the level-held memory request (`mem_req_vld`/`mem_ack_vld`) produced by the snapshot front end and drives one single-port synchronous SRAM with a fixed read latency. Arbitrates SRAM cycles between that register path and a hardware datapath port. Hardware has priority, with a starvation bound that guarantees register-access progress.

---
 rtl/reg_mem_bridge_pkg.sv | 13 +
 rtl/starve_arb.sv | 48 ++++
 rtl/reg_mem_sram_bridge.sv | 137 +++++++++++++
 3 files changed

// File: rtl/reg_mem_bridge_pkg.sv
// Shared types and counter widths for the register-access SRAM bridge.
package reg_mem_bridge_pkg;

  localparam int unsigned LatCntW    = 3;
  localparam int unsigned StarveCntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StAck
  } state_e;

endpackage

// File: rtl/starve_arb.sv
// SRAM arbiter: hardware port has priority, but a pending register access loses at most
// MAX_WAIT consecutive cycles before it is forced through.
module starve_arb
  import reg_mem_bridge_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic soft_rst,
  input  logic reg_pend,
  input  logic hw_req,
  input  logic hw_en,
  output logic reg_win,
  output logic hw_gnt
);

  localparam logic [StarveCntW-1:0] MaxWait = StarveCntW'(MAX_WAIT);

  logic [StarveCntW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    reg_win      = 1'b0;
    hw_gnt       = 1'b0;
    starve_cnt_d = '0;
    if (reg_pend) begin
      if (hw_req && (starve_cnt_q < MaxWait)) begin
        hw_gnt       = 1'b1;
        starve_cnt_d = starve_cnt_q + 1'b1;
      end else begin
        reg_win = 1'b1;
      end
    end else begin
      hw_gnt = hw_req & hw_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else if (soft_rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/reg_mem_sram_bridge.sv
// Terminal stage of the register memory path: serves level-held register requests on a
// single-port fixed-latency SRAM shared with a priority hardware port.
module reg_mem_sram_bridge
  import reg_mem_bridge_pkg::*;
#(
  parameter int unsigned MEM_DATA_WIDTH  = 64,
  parameter int unsigned MEM_ADDR_WIDTH  = 32,
  parameter int unsigned SRAM_ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY      = 2,
  parameter int unsigned MAX_WAIT        = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       soft_rst,
  input  logic                       mem_req_vld,
  output logic                       mem_ack_vld,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  input  logic                       mem_wr_en,
  input  logic                       mem_rd_en,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_wr_data,
  output logic [MEM_DATA_WIDTH-1:0]  mem_rd_data,
  output logic                       oor_err,
  input  logic                       hw_req,
  input  logic                       hw_we,
  input  logic [SRAM_ADDR_WIDTH-1:0] hw_addr,
  input  logic [MEM_DATA_WIDTH-1:0]  hw_wdata,
  output logic                       hw_gnt,
  output logic [MEM_DATA_WIDTH-1:0]  hw_rdata,
  output logic                       sram_cs,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [MEM_DATA_WIDTH-1:0]  sram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]  sram_rdata
);

  state_e                    state_q, state_d;
  logic [LatCntW-1:0]        lat_cnt_q, lat_cnt_d;
  logic [MEM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                      oor_q, oor_d;
  logic                      active, req_idle, in_range, reg_win;

  // Async reset and soft reset both suppress any SRAM cycle combinationally.
  assign active   = rst_n & ~soft_rst;
  assign req_idle = (state_q == StIdle) & mem_req_vld;
  assign in_range = (mem_addr >> SRAM_ADDR_WIDTH) == '0;

  starve_arb #(
    .MAX_WAIT(MAX_WAIT)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .soft_rst (soft_rst),
    .reg_pend (active & req_idle & in_range),
    .hw_req   (hw_req),
    .hw_en    (active & ~(req_idle & ~in_range)),
    .reg_win  (reg_win),
    .hw_gnt   (hw_gnt)
  );

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    rd_data_d = rd_data_q;
    oor_d     = oor_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req_vld) begin
          if (!in_range) begin
            oor_d     = 1'b1;
            rd_data_d = '0;
            state_d   = StAck;
          end else if (reg_win) begin
            if (mem_rd_en) begin
              lat_cnt_d = LatCntW'(RD_LATENCY - 1);
              state_d   = StRdWait;
            end else begin
              state_d = StAck;
            end
          end
        end
      end
      StRdWait: begin
        if (lat_cnt_q == '0) begin
          rd_data_d = sram_rdata;
          state_d   = StAck;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lat_cnt_q <= '0;
      rd_data_q <= '0;
      oor_q     <= 1'b0;
    end else if (soft_rst) begin
      state_q   <= StIdle;
      lat_cnt_q <= '0;
      rd_data_q <= '0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      rd_data_q <= rd_data_d;
      oor_q     <= oor_d;
    end
  end

  assign mem_ack_vld = (state_q == StAck);
  assign mem_rd_data = rd_data_q;
  assign oor_err     = oor_q;
  assign hw_rdata    = sram_rdata;

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (reg_win) begin
      sram_cs    = 1'b1;
      sram_we    = mem_wr_en;
      sram_addr  = mem_addr[SRAM_ADDR_WIDTH-1:0];
      sram_wdata = mem_wr_data;
    end else if (hw_gnt) begin
      sram_cs    = 1'b1;
      sram_we    = hw_we;
      sram_addr  = hw_addr;
      sram_wdata = hw_wdata;
    end
  end

endmodule
